// File: rtl/fifo_read_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_read_ctrl
//
// Read-side controller for a synchronous FIFO. On a start command it drains
// burst_len words from the FIFO read port and presents them on a valid/ready
// output stream. A 2-entry skid buffer absorbs the FIFO's 1-cycle read
// latency, so downstream backpressure never loses data and no read is ever
// issued to an empty FIFO.
//
// Handshake: a word moves on the m_* stream in every cycle where m_valid and
// m_ready are both 1 at the rising edge. m_valid never depends on m_ready.
// While m_valid=1 and m_ready=0, m_data and m_last hold stable.
//
// Ports:
//   clk            clock, rising edge
//   rst            synchronous, active-high reset
//   start          1-cycle burst request, sampled only in IDLE
//   burst_len      words to read, sampled with start (1..BURST_MAX is legal)
//   abort          terminates the active burst (honoured only in READ)
//   fifo_rd_en     FIFO read enable (combinational)
//   fifo_data_out  FIFO read data, valid 1 cycle after fifo_rd_en is sampled
//   fifo_empty     FIFO empty flag
//   m_valid        output word valid
//   m_data         output word (skid buffer head)
//   m_last         final word of the burst, qualified by m_valid
//   m_ready        downstream accept
//   busy           high in READ or FLUSH
//   done           1-cycle pulse when a burst completes or an abort finishes
//   err            1-cycle pulse when a start is rejected
//   words_done     words transferred on m_* in the current or last burst
//   dbg_state      current FSM state (0=IDLE, 1=READ, 2=FLUSH)
// -----------------------------------------------------------------------------
module fifo_read_ctrl #(
   parameter int DATA_WIDTH = 16,
   parameter int BURST_MAX  = 8,
   parameter int LEN_W      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [LEN_W-1:0]      burst_len,
   input  logic                  abort,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_data_out,
   input  logic                  fifo_empty,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   input  logic                  m_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [LEN_W-1:0]      words_done,
   output logic [1:0]            dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   localparam logic [LEN_W-1:0] BURST_MAX_L = LEN_W'(BURST_MAX);
   localparam logic [LEN_W-1:0] ONE_L       = LEN_W'(1);

   state_t                 state;
   state_t                 state_nxt;

   logic [LEN_W-1:0]       issue_cnt;   // reads still to be issued
   logic [LEN_W-1:0]       xfer_cnt;    // words still to be transferred
   logic [LEN_W-1:0]       words_cnt;
   logic                   inflight;    // a read was issued last cycle
   logic [DATA_WIDTH-1:0]  buf0;        // skid buffer head
   logic [DATA_WIDTH-1:0]  buf1;        // skid buffer second entry
   logic [1:0]             buf_cnt;
   logic                   done_q;
   logic                   err_q;

   logic                   len_ok;
   logic                   accept_start;
   logic                   pop;
   logic                   push;
   logic                   final_xfer;
   logic                   room_ok;
   logic [2:0]             occ_sum;
   logic [2:0]             occ_lim;
   logic                   done_nxt;
   logic                   err_nxt;
   logic                   flush_buf;

   // ---------------------------------------------------------------------
   // Datapath decode
   // ---------------------------------------------------------------------
   assign len_ok       = (burst_len != '0) && (burst_len <= BURST_MAX_L);
   assign accept_start = (state == S_IDLE) && start && len_ok;

   // The buffer only drives the stream in READ; FLUSH hides whatever is left.
   assign m_valid    = (state == S_READ) && (buf_cnt != 2'd0);
   assign m_data     = buf0;
   assign m_last     = m_valid && (xfer_cnt == ONE_L);
   assign pop        = m_valid && m_ready;
   assign final_xfer = pop && (xfer_cnt == ONE_L);

   // A returning word is only kept while still reading; in FLUSH it is dropped.
   assign push = inflight && (state == S_READ);

   // Buffered plus in-flight words must stay at or below 2 after this cycle.
   // A pop in the same cycle frees a slot, which is what lets a new read go
   // out every cycle and sustain one word per cycle with m_ready held high.
   assign occ_sum = {1'b0, buf_cnt} + {2'b00, inflight};
   assign occ_lim = 3'd2 + {2'b00, pop};
   assign room_ok = (occ_sum < occ_lim);

   // Gated by rst so a reset cycle never consumes a FIFO word.
   assign fifo_rd_en = !rst && (state == S_READ) && !abort &&
                       (issue_cnt != '0) && !fifo_empty && room_ok;

   // An abort that coincides with the final transfer takes the normal done
   // path, so the buffer is only thrown away on a genuine abort.
   assign flush_buf = ((state == S_READ) && abort && !final_xfer) ||
                      (state == S_FLUSH);

   // ---------------------------------------------------------------------
   // FSM: next-state and pulse decode
   // ---------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (len_ok) state_nxt = S_READ;
               else        err_nxt   = 1'b1;
            end
         end
         S_READ: begin
            if (final_xfer) begin
               state_nxt = S_IDLE;
               done_nxt  = 1'b1;
            end else if (abort) begin
               state_nxt = S_FLUSH;
            end
         end
         S_FLUSH: begin
            // Wait until no read can still be returning data.
            if (!inflight) begin
               state_nxt = S_IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM state register and control counters
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         issue_cnt <= '0;
         xfer_cnt  <= '0;
         words_cnt <= '0;
         inflight  <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state    <= state_nxt;
         done_q   <= done_nxt;
         err_q    <= err_nxt;
         inflight <= fifo_rd_en;

         if (accept_start) begin
            issue_cnt <= burst_len;
            xfer_cnt  <= burst_len;
            words_cnt <= '0;
         end else begin
            if (fifo_rd_en) issue_cnt <= issue_cnt - ONE_L;
            if (pop) begin
               xfer_cnt  <= xfer_cnt - ONE_L;
               words_cnt <= words_cnt + ONE_L;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // 2-entry skid buffer. buf0 is always the head; a pop shifts buf1 down.
   // The occupancy rule above guarantees no push arrives when it is full.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         buf0    <= '0;
         buf1    <= '0;
         buf_cnt <= 2'd0;
      end else if (flush_buf) begin
         buf_cnt <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (buf_cnt == 2'd0) buf0 <= fifo_data_out;
               else                 buf1 <= fifo_data_out;
               buf_cnt <= buf_cnt + 2'd1;
            end
            2'b01: begin
               buf0    <= buf1;
               buf_cnt <= buf_cnt - 2'd1;
            end
            2'b11: begin
               // Count unchanged; new word lands behind the remaining one.
               if (buf_cnt == 2'd1) begin
                  buf0 <= fifo_data_out;
               end else begin
                  buf0 <= buf1;
                  buf1 <= fifo_data_out;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Status outputs
   // ---------------------------------------------------------------------
   assign busy       = (state == S_READ) || (state == S_FLUSH);
   assign done       = done_q;
   assign err        = err_q;
   assign words_done = words_cnt;
   assign dbg_state  = state;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_read_ctrl
//
// Directed bench for fifo_read_ctrl. A small FIFO model feeds the read port,
// a monitor records every accepted output word, and a scoreboard of expected
// words is compared against the record after each burst.
// -----------------------------------------------------------------------------
module tb_fifo_read_ctrl;

   localparam int DW = 16;
   localparam int LW = 4;

   // ---------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   always #5 clk = ~clk;

   logic          start = 1'b0;
   logic [LW-1:0] burst_len = '0;
   logic          abort = 1'b0;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_data_out = '0;
   logic          fifo_empty;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic          m_ready = 1'b0;
   logic          busy;
   logic          done;
   logic          err;
   logic [LW-1:0] words_done;
   logic [1:0]    dbg_state;

   fifo_read_ctrl #(.DATA_WIDTH(DW), .BURST_MAX(8), .LEN_W(LW)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .burst_len     (burst_len),
      .abort         (abort),
      .fifo_rd_en    (fifo_rd_en),
      .fifo_data_out (fifo_data_out),
      .fifo_empty    (fifo_empty),
      .m_valid       (m_valid),
      .m_data        (m_data),
      .m_last        (m_last),
      .m_ready       (m_ready),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .words_done    (words_done),
      .dbg_state     (dbg_state)
   );

   // ---------------------------------------------------------------------
   // FIFO model: registered read port, words written by the stimulus.
   // ---------------------------------------------------------------------
   logic [DW-1:0] mem [0:63];
   int            wr_ptr = 0;
   int            rd_ptr = 0;
   int            underflow_cnt = 0;

   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (fifo_rd_en) begin
         if (wr_ptr == rd_ptr) begin
            underflow_cnt <= underflow_cnt + 1;
         end else begin
            fifo_data_out <= mem[rd_ptr[5:0]];
            rd_ptr        <= rd_ptr + 1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Output monitor: records transfers and watches hold-during-stall.
   // ---------------------------------------------------------------------
   logic [DW-1:0] obs_data [0:255];
   logic          obs_last [0:255];
   int            obs_cnt = 0;
   int            stall_viol = 0;
   logic          prev_stall = 1'b0;
   logic          prev_abort = 1'b0;
   logic          prev_rst = 1'b0;
   logic [DW-1:0] prev_data = '0;
   logic          prev_last = 1'b0;

   always @(posedge clk) begin
      if (!rst && m_valid && m_ready) begin
         obs_data[obs_cnt[7:0]] <= m_data;
         obs_last[obs_cnt[7:0]] <= m_last;
         obs_cnt                <= obs_cnt + 1;
      end
      if (prev_stall && !prev_abort && !prev_rst) begin
         if (!m_valid || (m_data != prev_data) || (m_last != prev_last))
            stall_viol <= stall_viol + 1;
      end
      prev_stall <= m_valid && !m_ready;
      prev_abort <= abort;
      prev_rst   <= rst;
      prev_data  <= m_data;
      prev_last  <= m_last;
   end

   // ---------------------------------------------------------------------
   // Scoreboard and checking
   // ---------------------------------------------------------------------
   logic [DW-1:0] exp_q [$];
   int            n_checks = 0;
   int            n_errs = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Compare n recorded words starting at base against the expected queue.
   task automatic score(input string tag, input int base, input int n);
      logic [DW-1:0] e;
      for (int i = 0; i < n; i++) begin
         e = exp_q.pop_front();
         check($sformatf("%s_data%0d", tag, i), obs_data[base + i], e);
         check($sformatf("%s_last%0d", tag, i), obs_last[base + i], (i == n - 1));
      end
   endtask

   // ---------------------------------------------------------------------
   // Driver tasks. Everything is driven and checked 1 ns after a rising edge.
   // ---------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fifo_push(input logic [DW-1:0] d);
      mem[wr_ptr[5:0]] = d;
      wr_ptr++;
   endtask

   // Returns 1 ns after the edge that samples start.
   task automatic start_burst(input logic [LW-1:0] len);
      start     = 1'b1;
      burst_len = len;
      tick();
      start     = 1'b0;
   endtask

   task automatic wait_done(input int budget, output logic seen);
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   logic [3:0] rdy_pat;
   logic       seen;
   int         obs_base;
   int         rd_base;
   int         occ;
   int         max_occ;

   initial begin
      // ---- reset state ----
      rst = 1'b1;
      tick();
      tick();
      check("rst_m_valid", m_valid, 0);
      check("rst_m_last", m_last, 0);
      check("rst_m_data", m_data, 0);
      check("rst_rd_en", fifo_rd_en, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_words", words_done, 0);
      check("rst_state", dbg_state, 0);
      rst = 1'b0;
      tick();

      // ---- full burst of 8, m_ready held high ----
      for (int i = 0; i < 8; i++) fifo_push(16'hA001 + 16'(i));
      m_ready = 1'b1;
      start_burst(4'd8);
      check("t1_busy", busy, 1);
      check("t1_rd_en", fifo_rd_en, 1);
      check("t1_valid_c0", m_valid, 0);
      tick();
      check("t1_valid_c1", m_valid, 0);
      for (int k = 0; k < 8; k++) begin
         tick();
         check($sformatf("t1_valid%0d", k), m_valid, 1);
         check($sformatf("t1_data%0d", k), m_data, 16'hA001 + 16'(k));
         check($sformatf("t1_last%0d", k), m_last, (k == 7));
      end
      tick();
      check("t1_done", done, 1);
      check("t1_busy_end", busy, 0);
      check("t1_words", words_done, 8);
      check("t1_valid_end", m_valid, 0);
      tick();
      check("t1_done_pulse", done, 0);

      // ---- burst of 4 with m_ready toggling 1,0,0,1 ----
      for (int i = 0; i < 4; i++) begin
         fifo_push(16'hB001 + 16'(i));
         exp_q.push_back(16'hB001 + 16'(i));
      end
      rdy_pat  = 4'b1001;
      obs_base = obs_cnt;
      rd_base  = rd_ptr;
      max_occ  = 0;
      seen     = 1'b0;
      start_burst(4'd4);
      for (int c = 0; c < 40; c++) begin
         m_ready = rdy_pat[c % 4];
         tick();
         occ = (rd_ptr - rd_base) - (obs_cnt - obs_base);
         if (occ > max_occ) max_occ = occ;
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      check("t2_done", seen, 1);
      check("t2_count", obs_cnt - obs_base, 4);
      check("t2_max_outstanding_le2", (max_occ <= 2), 1);
      score("t2", obs_base, 4);
      m_ready = 1'b1;

      // ---- FIFO underruns mid-burst, then refills ----
      fifo_push(16'hC001);
      fifo_push(16'hC002);
      for (int i = 0; i < 5; i++) exp_q.push_back(16'hC001 + 16'(i));
      obs_base = obs_cnt;
      start_burst(4'd5);
      repeat (6) tick();
      check("t3_partial_cnt", obs_cnt - obs_base, 2);
      check("t3_stall_rd_en", fifo_rd_en, 0);
      check("t3_stall_empty", fifo_empty, 1);
      check("t3_stall_busy", busy, 1);
      check("t3_stall_valid", m_valid, 0);
      check("t3_stall_words", words_done, 2);
      for (int i = 2; i < 5; i++) fifo_push(16'hC001 + 16'(i));
      wait_done(20, seen);
      check("t3_done", seen, 1);
      check("t3_count", obs_cnt - obs_base, 5);
      check("t3_words", words_done, 5);
      score("t3", obs_base, 5);
      tick();

      // ---- rejected starts ----
      for (int i = 0; i < 8; i++) fifo_push(16'hE001 + 16'(i));
      rd_base = rd_ptr;
      start_burst(4'd0);
      check("t4_err_len0", err, 1);
      check("t4_busy_len0", busy, 0);
      check("t4_rd_en_len0", fifo_rd_en, 0);
      tick();
      check("t4_err_pulse", err, 0);
      start_burst(4'd9);
      check("t4_err_len9", err, 1);
      check("t4_busy_len9", busy, 0);
      check("t4_rd_en_len9", fifo_rd_en, 0);
      check("t4_words_kept", words_done, 5);
      tick();
      check("t4_no_reads", rd_ptr - rd_base, 0);

      // ---- abort on cycle 4 with m_ready low ----
      m_ready = 1'b0;
      rd_base = rd_ptr;
      start_burst(4'd8);
      tick();
      tick();
      tick();
      check("t5_pre_valid", m_valid, 1);
      check("t5_pre_data", m_data, 16'hE001);
      abort = 1'b1;
      check("t5_abort_rd_en", fifo_rd_en, 0);
      tick();
      abort = 1'b0;
      check("t5_flush_valid", m_valid, 0);
      check("t5_flush_busy", busy, 1);
      check("t5_flush_state", dbg_state, 2);
      tick();
      check("t5_done", done, 1);
      check("t5_busy_end", busy, 0);
      check("t5_words", words_done, 0);
      check("t5_state", dbg_state, 0);
      check("t5_lost", rd_ptr - rd_base, 2);

      // ---- reset mid-burst with 2 words buffered ----
      start_burst(4'd4);
      tick();
      tick();
      tick();
      check("t6_pre_valid", m_valid, 1);
      check("t6_pre_data", m_data, 16'hE003);
      rst = 1'b1;
      tick();
      check("t6_rst_valid", m_valid, 0);
      check("t6_rst_data", m_data, 0);
      check("t6_rst_rd_en", fifo_rd_en, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_done", done, 0);
      check("t6_rst_words", words_done, 0);
      check("t6_rst_state", dbg_state, 0);
      rst = 1'b0;
      m_ready = 1'b1;
      for (int i = 0; i < 3; i++) exp_q.push_back(16'hE005 + 16'(i));
      obs_base = obs_cnt;
      start_burst(4'd3);
      wait_done(20, seen);
      check("t6_done", seen, 1);
      check("t6_count", obs_cnt - obs_base, 3);
      score("t6", obs_base, 3);

      // ---- abort coinciding with the final transfer ----
      obs_base = obs_cnt;
      start_burst(4'd1);
      tick();
      check("t7_valid_c1", m_valid, 0);
      tick();
      check("t7_valid", m_valid, 1);
      check("t7_data", m_data, 16'hE008);
      check("t7_last", m_last, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t7_done", done, 1);
      check("t7_state", dbg_state, 0);
      check("t7_words", words_done, 1);
      check("t7_count", obs_cnt - obs_base, 1);
      tick();

      // ---- global invariants ----
      check("no_underflow_reads", underflow_cnt, 0);
      check("stall_hold", stall_viol, 0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

// File: doc/fifo_read_ctrl.md
Name: fifo_read_ctrl

Overview:
Read-side controller for the synchronous FIFO. It drains a commanded burst of words from the FIFO read port and presents them on a valid/ready output stream. A 2-entry skid buffer absorbs the FIFO's 1-cycle read latency, so output backpressure never causes data loss or a FIFO underflow read. It sits between the FIFO's read port and any downstream consumer.

Parameters:
DATA_WIDTH, 16, width of FIFO data_out and m_data
BURST_MAX, 8, largest legal burst length, equal to FIFO_DEPTH
LEN_W, 4, width of burst_len and words_done; must satisfy 2^LEN_W > BURST_MAX

Ports:
clk  input  1  clock; all logic is on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  1-cycle burst request, sampled only in IDLE
burst_len  input  LEN_W  words to read; sampled with start
abort  input  1  terminates the active burst
fifo_rd_en  output  1  FIFO read enable
fifo_data_out  input  DATA_WIDTH  FIFO read data; valid 1 cycle after fifo_rd_en is sampled
fifo_empty  input  1  FIFO empty flag
m_valid  output  1  output word valid
m_data  output  DATA_WIDTH  output word
m_last  output  1  marks the final word of the burst; qualified by m_valid
m_ready  input  1  downstream accept
busy  output  1  high in READ or FLUSH
done  output  1  1-cycle pulse when a burst completes or abort finishes
err  output  1  1-cycle pulse when a start is rejected
words_done  output  LEN_W  count of words transferred on m_* in the current or last burst

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE; skid buffer, in-flight flag and all counters are cleared.
  - fifo_rd_en, m_valid, m_last, busy, done, err are 0; m_data is 0; words_done is 0.
  - Reset in the middle of a burst discards buffered and in-flight data with no done pulse.
- States: IDLE, READ, FLUSH.
- IDLE:
  - start=1 with 1 <= burst_len <= BURST_MAX: load issue_cnt = burst_len and xfer_cnt = burst_len, clear words_done, go to READ.
  - start=1 with burst_len = 0 or burst_len > BURST_MAX: err=1 in the next cycle and stay in IDLE.
  - start=0: stay in IDLE.
- start is ignored outside IDLE; err stays 0.
- fifo_rd_en is combinational: READ and issue_cnt > 0 and !fifo_empty and (buf_cnt + inflight) < 2.
  - It is never asserted while fifo_empty=1, so no underflow read is ever issued.
- Each cycle fifo_rd_en=1: issue_cnt decrements; inflight is set for the next cycle.
- The cycle after a read issue, fifo_data_out is written into the skid buffer tail.
- Output stream:
  - m_valid = (buf_cnt > 0); m_data is the buffer head.
  - A transfer occurs when m_valid and m_ready are both 1.
  - Each transfer pops the head, decrements xfer_cnt and increments words_done.
  - While m_valid=1 and m_ready=0, m_data and m_last hold stable.
  - A push and a pop in the same cycle leave buf_cnt unchanged, and ordering is preserved.
- m_last = m_valid and (xfer_cnt == 1).
- READ to IDLE: the cycle after the transfer that brings xfer_cnt to 0, done=1 and busy=0.
- abort=1 in READ:
  - fifo_rd_en drops in the same cycle; go to FLUSH.
  - m_valid is forced to 0 from the next cycle.
- FLUSH:
  - Discards any in-flight word when it returns and clears the buffer.
  - Goes to IDLE when inflight=0, at most 2 cycles; done=1 on entry to IDLE.
  - words_done retains the count transferred before the abort.
- abort is ignored in IDLE and FLUSH.
- abort coinciding with the final transfer: the transfer completes and the normal done path wins.
- Throughput: with the FIFO non-empty and m_ready held at 1, one word per cycle after an initial 2-cycle latency from start.
- Stalls in the middle of a burst:
  - If fifo_empty rises mid-burst, issuing stalls and the burst stays in READ with no timeout.
  - Reads resume when fifo_empty falls.

Test Plan:
- Reset, then FIFO holding 0xA001..0xA008, start with burst_len=8, m_ready=1 -> first m_valid 2 cycles after start; 8 consecutive words 0xA001..0xA008; m_last only on 0xA008; done the next cycle; words_done=8.
- burst_len=4, m_ready toggling 1,0,0,1,... -> no word lost or duplicated; m_data stable during stalls; never more than 2 reads outstanding.
- FIFO holding 2 words, burst_len=5 -> 2 words out, then fifo_rd_en=0 while fifo_empty=1. Write 3 more words -> remaining 3 words out with m_last on the 5th; done pulse.
- start with burst_len=0, then with burst_len=9 -> err pulse each time; no fifo_rd_en; busy stays 0.
- burst_len=8, m_ready=0, abort on cycle 4 -> FLUSH; m_valid=0; done within 2 cycles; words_done=0; FIFO has lost at most 2 words.
- rst=1 in the middle of a burst with 2 words buffered -> next cycle all outputs 0 and state IDLE. A new start with burst_len=3 then returns the next 3 FIFO words correctly.
